// File: rtl/morse_char_capture.sv
// morse_char_capture: classifies marks/spaces of a keyed signal into one Morse character per strobe
module morse_char_capture #(
   parameter int PULSE_CNT_W   = 16,
   parameter int MAX_MORSE_LEN = 8,
   parameter int MORSE_LEN_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   input  logic                     start,
   input  logic [PULSE_CNT_W-1:0]   dit_time,
   input  logic [PULSE_CNT_W-1:0]   dah_time,
   input  logic [PULSE_CNT_W-1:0]   word_time,
   input  logic [PULSE_CNT_W-1:0]   tol_time,
   input  logic                     signal,
   output logic [MORSE_LEN_W-1:0]   len,
   output logic [MAX_MORSE_LEN-1:0] dits_dahs,
   output logic                     error,
   output logic                     word_end,
   output logic                     ceo
);
   typedef enum logic [2:0] {IDLE, WAIT_MARK, MARK, SPACE, WAIT_WORD} state_t;
   state_t                   state_q;
   logic [PULSE_CNT_W-1:0]   cnt_q, cnt_d, chr_thr, wrd_thr, dit_dev, dah_dev;
   logic [MORSE_LEN_W-1:0]   len_q;
   logic [MAX_MORSE_LEN-1:0] bits_q, mask;
   logic                     err_q, ceo_q, we_q, dit_ok, dah_ok, elem, full;
   // Saturating count, gap thresholds clamped at zero, and mark classification
   always_comb begin
      cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
      chr_thr = dah_time > tol_time ? dah_time - tol_time : '0;
      wrd_thr = word_time > tol_time ? word_time - tol_time : '0;
      dit_dev = cnt_q >= dit_time ? cnt_q - dit_time : dit_time - cnt_q;
      dah_dev = cnt_q >= dah_time ? cnt_q - dah_time : dah_time - cnt_q;
      dit_ok  = dit_dev <= tol_time;
      dah_ok  = dah_dev <= tol_time;
      elem    = dit_ok ? 1'b0 : dah_ok ? 1'b1 : cnt_q > dit_time;
      full    = len_q == MORSE_LEN_W'(MAX_MORSE_LEN);
      mask    = MAX_MORSE_LEN'(elem) << len_q;
   end
   // Capture FSM; a held-back word strobe keeps ceo from firing on back-to-back clocks
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         bits_q  <= '0;
         err_q   <= 1'b0;
         ceo_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         ceo_q <= 1'b0;
         we_q  <= 1'b0;
         if (start) begin
            state_q <= WAIT_MARK;
            cnt_q   <= '0;
            len_q   <= '0;
            bits_q  <= '0;
            err_q   <= 1'b0;
         end else if (ce) begin
            case (state_q)
               WAIT_MARK, WAIT_WORD: begin
                  if (signal) begin
                     state_q <= MARK;
                     cnt_q   <= PULSE_CNT_W'(1);
                     len_q   <= '0;
                     bits_q  <= '0;
                     err_q   <= 1'b0;
                  end else if (state_q == WAIT_WORD) begin
                     cnt_q <= cnt_d;
                     if (cnt_d >= wrd_thr && !ceo_q) begin
                        ceo_q   <= 1'b1;
                        we_q    <= 1'b1;
                        state_q <= IDLE;
                     end
                  end
               end
               MARK: begin
                  if (signal) cnt_q <= cnt_d;
                  else begin
                     cnt_q   <= PULSE_CNT_W'(1);
                     state_q <= SPACE;
                     if (full) err_q <= 1'b1;
                     else begin
                        len_q  <= len_q + 1'b1;
                        bits_q <= bits_q | mask;
                        err_q  <= err_q | (!dit_ok && !dah_ok);
                     end
                  end
               end
               SPACE: begin
                  if (signal && cnt_q < chr_thr) begin
                     cnt_q   <= PULSE_CNT_W'(1);
                     state_q <= MARK;
                  end else begin
                     cnt_q <= cnt_d;
                     if (cnt_d >= chr_thr) begin
                        ceo_q   <= 1'b1;
                        state_q <= WAIT_WORD;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign len       = len_q;
   assign dits_dahs = bits_q;
   assign error     = err_q;
   assign word_end  = we_q;
   assign ceo       = ceo_q;
endmodule

// File: tb/tb_morse_char_capture.sv
// tb_morse_char_capture: directed vectors and sequences for the Morse character capture block
module tb_morse_char_capture;
   logic        clk = 0, rst = 0, ce = 1, start = 0, signal = 0;
   logic [15:0] dit_time = 10, dah_time = 30, word_time = 70, tol_time = 5;
   logic [3:0]  len;
   logic [7:0]  dits_dahs;
   logic        error, word_end, ceo;
   int checks = 0, errors = 0, n_ceo = 0;
   logic got = 0, prev = 0, tgl = 0;
   int g_len, g_bits, g_err, g_we;
   typedef struct {int mark; int bit_v; int err;} vec_t;
   vec_t vecs[12];

   morse_char_capture dut (.clk(clk), .rst(rst), .ce(ce), .start(start), .dit_time(dit_time),
      .dah_time(dah_time), .word_time(word_time), .tol_time(tol_time), .signal(signal),
      .len(len), .dits_dahs(dits_dahs), .error(error), .word_end(word_end), .ceo(ceo));

   always #5 clk = ~clk;

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clk1();
      @(negedge clk);
      if (ceo) begin
         got = 1; n_ceo++;
         g_len = int'(len); g_bits = int'(dits_dahs); g_err = int'(error); g_we = int'(word_end);
         if (prev) begin
            errors++;
            $display("FAIL ceo_consecutive: got 1 expected 0");
         end
      end
      prev = ceo;
   endtask

   task automatic step();
      if (tgl) begin
         ce = 0; clk1(); ce = 1;
      end
      clk1();
   endtask

   task automatic pulse_start();
      start = 1; clk1(); start = 0;
   endtask

   task automatic mark(int n);
      signal = 1;
      repeat (n) step();
      signal = 0;
   endtask

   task automatic send(string s);
      for (int i = 0; i < s.len(); i++) begin
         mark(s[i] == "-" ? 30 : 10);
         if (i != s.len() - 1) repeat (10) step();
      end
   endtask

   task automatic wait_ceo(string nm, int exp_n, int e_len, int e_bits, int e_err, int e_we);
      int n = 0;
      got = 0;
      while (!got && n < 300) begin
         step(); n++;
      end
      chk({nm, "_seen"}, int'(got), 1);
      if (got) begin
         chk({nm, "_ticks"}, n, exp_n);
         chk({nm, "_len"}, g_len, e_len);
         chk({nm, "_bits"}, g_bits, e_bits);
         chk({nm, "_err"}, g_err, e_err);
         chk({nm, "_word_end"}, g_we, e_we);
      end
   endtask

   initial begin
      int n0;
      vecs = '{'{10, 0, 0}, '{30, 1, 0}, '{5, 0, 0}, '{15, 0, 0}, '{25, 1, 0}, '{35, 1, 0},
               '{4, 0, 1}, '{16, 1, 1}, '{36, 1, 1}, '{20, 1, 1}, '{1, 0, 1}, '{31, 1, 0}};
      rst = 1; clk1(); clk1(); rst = 0;
      chk("rst_len", int'(len), 0);
      chk("rst_bits", int'(dits_dahs), 0);
      chk("rst_err", int'(error), 0);
      chk("rst_word_end", int'(word_end), 0);
      chk("rst_ceo", int'(ceo), 0);
      pulse_start();
      send("--.-.");
      wait_ceo("c_gngn", 25, 5, 8'h0B, 0, 0);
      send("...");
      wait_ceo("c_s", 25, 3, 0, 0, 0);
      send("---");
      wait_ceo("c_o", 25, 3, 7, 0, 0);
      wait_ceo("w1", 40, 3, 7, 0, 1);
      n0 = n_ceo;
      send(".");
      repeat (100) step();
      chk("idle_no_ceo", n_ceo - n0, 0);
      chk("idle_len", int'(len), 3);
      foreach (vecs[i]) begin
         pulse_start();
         mark(vecs[i].mark);
         wait_ceo($sformatf("mark%0d", vecs[i].mark), 25, 1, vecs[i].bit_v, vecs[i].err, 0);
      end
      pulse_start();
      mark(10);
      wait_ceo("e_t1", 25, 1, 0, 0, 0);
      mark(30);
      wait_ceo("e_t2", 25, 1, 1, 0, 0);
      wait_ceo("e_t_word", 40, 1, 1, 0, 1);
      pulse_start();
      send(".........");
      wait_ceo("overflow", 25, 8, 0, 1, 0);
      tgl = 1;
      pulse_start();
      send("-.");
      wait_ceo("ce_half", 25, 2, 1, 0, 0);
      wait_ceo("ce_half_word", 40, 2, 1, 0, 1);
      tgl = 0;
      ce = 1;
      pulse_start();
      mark(10);
      repeat (3) step();
      signal = 1;
      repeat (5) step();
      rst = 1; clk1(); rst = 0; signal = 0;
      chk("midrst_len", int'(len), 0);
      chk("midrst_bits", int'(dits_dahs), 0);
      chk("midrst_err", int'(error), 0);
      chk("midrst_ceo", int'(ceo), 0);
      n0 = n_ceo;
      send(".");
      repeat (100) step();
      chk("midrst_no_ceo", n_ceo - n0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/morse_char_capture.md
Name: morse_char_capture

Overview:
- Decodes one Morse character at a time from a sampled on/off keying signal.
- Classifies each mark as a dit or a dah, and each space as an intra-character, character or word gap, using programmable time thresholds counted in clock-enable ticks.
- Emits the captured element pattern with a one-cycle strobe per character, then a second strobe on word end.
- Sits between the input synchroniser/pulse-timing stage and the Morse-to-ASCII lookup.

Parameters:
PULSE_CNT_W, 16, width of all time inputs and internal duration counter
MAX_MORSE_LEN, 8, maximum elements per character (width of dits_dahs)
MORSE_LEN_W, 4, width of len; must hold MAX_MORSE_LEN

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ce  in  1  clock enable; all timing and state advance only when ce=1
start  in  1  arm capture; takes priority over everything except rst
dit_time  in  PULSE_CNT_W  nominal dit mark length, in ce ticks
dah_time  in  PULSE_CNT_W  nominal dah length; also the nominal character gap
word_time  in  PULSE_CNT_W  nominal word gap
tol_time  in  PULSE_CNT_W  allowed +/- deviation
signal  in  1  keying input, 1 = mark
len  out  MORSE_LEN_W  number of elements captured
dits_dahs  out  MAX_MORSE_LEN  element i at bit i (first element = bit 0); 0 = dit, 1 = dah; bits >= len are 0
error  out  1  character malformed
word_end  out  1  qualifies ceo as a word-end event
ceo  out  1  one-cycle output strobe

Behaviour:
- Reset: state IDLE; len, dits_dahs, error, word_end, ceo all 0; counter 0.
- States: IDLE, WAIT_MARK, MARK, SPACE, WAIT_WORD.
- IDLE: ignores signal until start.
- start=1 in any state (ce ignored for start):
  - go to WAIT_MARK;
  - clear len, dits_dahs, error, word_end;
  - ceo=0.
- WAIT_MARK:
  - waits indefinitely while signal=0; no timeout.
  - On ce with signal=1: clear len, dits_dahs and error (fresh character), set counter=1, go to MARK.
- MARK (per ce tick):
  - signal=1: counter increments, saturating at all-ones.
  - signal=0: classify counter value d, then set counter=1 and go to SPACE.
  - Classification:
    - |d-dit_time| <= tol_time: dit, append 0.
    - else |d-dah_time| <= tol_time: dah, append 1.
    - else: error=1; element still counted, recorded as dah if d > dit_time, otherwise dit.
  - If len already equals MAX_MORSE_LEN: error=1; len and bits unchanged.
  - Use unsigned compares with no underflow: treat (x-tol) as 0 when tol > x.
- SPACE (per ce tick):
  - signal=1 with counter < dah_time-tol_time: intra-character gap; counter=1, back to MARK. Gap length is not otherwise checked.
  - Counter reaching dah_time-tol_time while still low: character end.
    - Pulse ceo=1 for one clk with word_end=0.
    - len, dits_dahs and error are valid on that cycle and stay stable until the next character starts.
    - Go to WAIT_WORD; counter keeps counting.
- WAIT_WORD (per ce tick):
  - signal=1: new character; clear len, dits_dahs and error; counter=1; go to MARK.
  - Counter reaching word_time-tol_time: pulse ceo=1 with word_end=1 for one clk, then go to IDLE. A new start is required for the next word.
- ceo is never high on two consecutive clocks; word_end is meaningful only when ceo=1 and is 0 otherwise.
- ceo is asserted only on clocks where ce=1.
- A mark of length 0 cannot occur (minimum 1 tick).
- Glitch filtering is out of scope.

Test Plan:
- rst, then start; dit=10, dah=30, word=70, tol=5, ce=1. Send "--.-." with 10-tick element gaps, then 31 low -> ceo, word_end=0, len=5, dits_dahs=01011 (bit0=dah), error=0.
- Continue: send "...", 31 low -> len=3, bits 000. Then "---" followed by 71 low -> char strobe len=3, bits 111; then a later ceo with word_end=1. Module then sits in IDLE and ignores further marks.
- start; single ".", gap 31; single "-", gap 71 -> len=1 bits 0; then len=1 bits 1; then word end.
- Mark of 20 ticks (outside both windows) -> char strobe with error=1.
- Send 9 dits (MAX=8) -> error=1, len=8.
- Tolerance edges: marks of 5, 15, 25 and 35 ticks classify as dit, dit, dah, dah. Marks of 4, 16 and 36 ticks set error.
- ce toggled 1/0 every clock -> same results with durations counted in ce ticks. rst mid-character -> all outputs 0 and no ceo until the next start.
